// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: PC generator, 1-cycle imem read and {instr, pc} FIFO toward decode with branch redirect
module instr_fetch_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    pc_wb,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc_out,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     fetch_pc, req_pc;
    logic                inflight;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [INSTR_W-1:0]  mem_i [DEPTH];
    logic [PC_W-1:0]     mem_p [DEPTH];
    logic [CW:0]         occ;
    logic                wr, pop, has;

    assign fifo_count = count;

    // fetch mode register
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nxt;

    // next state, credit-based request, redirect target and head outputs; a redirect sees an empty FIFO
    always_comb begin
        state_nxt   = fetch_en ? RUN : IDLE;
        occ         = branch_taken ? '0 : {1'b0, count} + (CW+1)'(inflight);
        imem_rd_en  = reset && (state == RUN || fetch_en) && occ < LIM;
        imem_addr   = (reset && branch_taken) ? pc_wb : fetch_pc;
        wr          = inflight && !branch_taken;
        has         = count != '0;
        instr_valid = reset && has && !branch_taken;
        pop         = instr_valid && instr_ready;
        instr       = has ? mem_i[rd_ptr] : '0;
        pc_out      = has ? mem_p[rd_ptr] : '0;
    end

    // PC, in-flight tracking and FIFO bookkeeping; a redirect clears everything queued
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            fetch_pc <= RST_PC;
            req_pc   <= RST_PC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                fetch_pc <= imem_addr + PC_W'(1);
                req_pc   <= imem_addr;
            end else if (branch_taken) begin
                fetch_pc <= pc_wb;
            end
            if (branch_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr)  wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(wr) - CW'(pop);
            end
        end

    // FIFO storage, written by the returning read
    always_ff @(posedge clk)
        if (wr) begin
            mem_i[wr_ptr] <= imem_data;
            mem_p[wr_ptr] <= req_pc;
        end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(wr && count == CW'(DEPTH)));
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: randomized bench against a queue-based model of the fetch buffer
module tb_instr_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0, reset = 1'b0, fetch_en = 1'b0, branch_taken = 1'b0, instr_ready = 1'b0;
    logic        imem_rd_en, instr_valid;
    logic [7:0]  imem_addr, pc_wb = '0, pc_out;
    logic [31:0] imem_data = '0, instr;
    logic [2:0]  fifo_count;

    int checks = 0, errors = 0;

    logic [31:0] mem [256];
    bit          m_run, m_infl;
    logic [7:0]  m_pc, m_req;
    logic [7:0]  q [$];
    logic [31:0] nd;

    always #5 clk = ~clk;

    instr_fetch_buffer dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .branch_taken(branch_taken), .pc_wb(pc_wb), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .pc_out(pc_out), .fifo_count(fifo_count)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(bit fe, bit rdy, bit bt, logic [7:0] wb);
        bit         e_rd, e_val;
        logic [7:0] e_addr, head;
        int         occ;
        @(negedge clk);
        fetch_en = fe; instr_ready = rdy; branch_taken = bt; pc_wb = wb; imem_data = nd;
        #1;
        occ    = bt ? 0 : q.size() + int'(m_infl);
        e_rd   = (m_run || fe) && occ < DEPTH;
        e_addr = bt ? wb : m_pc;
        e_val  = q.size() != 0 && !bt;
        head   = q.size() != 0 ? q[0] : 8'h00;
        check("rd_en", 32'(imem_rd_en), 32'(e_rd));
        check("addr", 32'(imem_addr), 32'(e_addr));
        check("valid", 32'(instr_valid), 32'(e_val));
        check("count", 32'(fifo_count), 32'(q.size()));
        check("pc_out", 32'(pc_out), 32'(head));
        check("instr", instr, q.size() != 0 ? mem[head] : 32'h0);
        nd = imem_rd_en ? mem[imem_addr] : $urandom();
        @(posedge clk);
        if (bt) q.delete();
        else begin
            if (e_val && rdy) void'(q.pop_front());
            if (m_infl) q.push_back(m_req);
        end
        if (e_rd) begin
            m_req = e_addr;
            m_pc  = e_addr + 8'd1;
        end else if (bt) m_pc = wb;
        m_infl = e_rd;
        m_run  = fe;
    endtask

    task automatic do_reset();
        #2;
        fetch_en = 1'b0; branch_taken = 1'b0; instr_ready = 1'b0; pc_wb = 8'h5A;
        reset = 1'b0;
        #1;
        check("rst_rd_en", 32'(imem_rd_en), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_pc_out", 32'(pc_out), 0);
        check("rst_instr", instr, 0);
        q.delete();
        m_run = 0; m_infl = 0; m_pc = 8'h00; m_req = 8'h00; nd = $urandom();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = $urandom();
        do_reset();
        repeat (8) step(1, 1, 0, 8'h00);
        repeat (10) step(1, 0, 0, 8'h00);
        #1;
        check("full_count", 32'(fifo_count), 4);
        check("full_stall", 32'(imem_rd_en), 0);
        do_reset();
        repeat (4) step(1, 0, 0, 8'h00);
        step(1, 0, 1, 8'h40);
        repeat (4) step(1, 1, 0, 8'h00);
        step(1, 1, 1, 8'hFE);
        repeat (6) step(1, 1, 0, 8'h00);
        repeat (3) step(1, 0, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(1, 1, 1, 8'h10);
        repeat (3) step(1, 1, 0, 8'h00);
        step(0, 0, 1, 8'h80);
        repeat (3) step(1, 1, 0, 8'h00);
        repeat (4) step(1, 0, 0, 8'h00);
        do_reset();
        repeat (4) step(1, 1, 0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 3) == 0 ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom()));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
